// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, state encoding and GF(2^8) helpers
package aes_pkg;
  typedef logic [127:0] aes_block_t;
  typedef logic [31:0]  aes_word_t;
  typedef logic [7:0]   byte_t;
  typedef logic [3:0]   round_t;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ROUND = 2'd1, ST_DONE = 2'd2} aes_state_e;

  localparam byte_t RCON_START = 8'h01;

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gf_mul(input byte_t a, input byte_t b);
    byte_t p, aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction
endpackage

// File: rtl/aes_enc_core_if.sv
// rtl/aes_enc_core_if.sv - block-in / ciphertext-out handshake bundle for aes_enc_core
interface aes_enc_core_if #(parameter int KEY_BITS = 128);
  import aes_pkg::*;

  logic                in_valid;
  logic                in_ready;
  aes_block_t          in_data;
  logic [KEY_BITS-1:0] in_key;
  logic                out_valid;
  logic                out_ready;
  aes_block_t          out_data;
  logic                busy;

  modport master (output in_valid, in_data, in_key, out_ready,
                  input  in_ready, out_valid, out_data, busy);
  modport slave  (input  in_valid, in_data, in_key, out_ready,
                  output in_ready, out_valid, out_data, busy);
endinterface

// File: rtl/aes_key_expand_step.sv
// rtl/aes_key_expand_step.sv - one on-the-fly key schedule step producing four new words
module aes_key_expand_step import aes_pkg::*; #(
  parameter int KEY_BITS = 128
) (
  input  logic [KEY_BITS-1:0] win,
  input  byte_t               rcon,
  input  logic                phase,
  output logic [KEY_BITS-1:0] next_win,
  output byte_t               next_rcon,
  output aes_block_t          round_key
);
  aes_word_t last, sub, t, n0, n1, n2, n3;
  logic      use_rot;

  assign last = win[KEY_BITS-1 -: 32];

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (.a(last[8*i +: 8]), .y(sub[8*i +: 8]));
  end

  // AES-256 odd rounds take SubWord only; rotation commutes with the bytewise S-box
  assign use_rot   = (KEY_BITS == 128) || phase;
  assign t         = use_rot ? ({sub[7:0], sub[31:8]} ^ {24'h0, rcon}) : sub;
  assign next_rcon = use_rot ? xtime(rcon) : rcon;

  assign n0 = win[31:0]  ^ t;
  assign n1 = win[63:32] ^ n0;
  assign n2 = win[95:64] ^ n1;
  assign n3 = win[127:96] ^ n2;
  assign round_key = {n3, n2, n1, n0};

  if (KEY_BITS == 128) begin : g_win128
    assign next_win = round_key;
  end else begin : g_win256
    assign next_win = {round_key, win[KEY_BITS-1:128]};
  end
endmodule

// File: rtl/aes_mixw.sv
// rtl/aes_mixw.sv - MixColumns on one state column (row 0 in the low byte)
module aes_mixw import aes_pkg::*; (
  input  aes_word_t w,
  output aes_word_t y
);
  byte_t b0, b1, b2, b3;

  assign {b3, b2, b1, b0} = w;

  assign y[7:0]   = xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3;
  assign y[15:8]  = b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3;
  assign y[23:16] = b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3;
  assign y[31:24] = xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3);
endmodule

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - AES forward S-box: GF(2^8) inverse (a^254) followed by the affine map
module aes_sbox import aes_pkg::*; (
  input  byte_t a,
  output byte_t y
);
  byte_t a2, a3, a6, a12, a15, a30, a60, a120, a240, inv;

  // addition chain 2,3,6,12,15,30,60,120,240 -> 240+12+2 = 254; zero maps to zero
  assign a2   = gf_mul(a, a);
  assign a3   = gf_mul(a2, a);
  assign a6   = gf_mul(a3, a3);
  assign a12  = gf_mul(a6, a6);
  assign a15  = gf_mul(a12, a3);
  assign a30  = gf_mul(a15, a15);
  assign a60  = gf_mul(a30, a30);
  assign a120 = gf_mul(a60, a60);
  assign a240 = gf_mul(a120, a120);
  assign inv  = gf_mul(gf_mul(a240, a12), a2);

  assign y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

// File: rtl/aes_enc_core.sv
// rtl/aes_enc_core.sv - iterative AES-128/256 encryptor, one round per clock, key expanded on the fly
module aes_enc_core import aes_pkg::*; #(
  parameter int KEY_BITS = 128
) (
  input logic           clk,
  input logic           resetn,
  aes_enc_core_if.slave bus
);
  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_enc_core: KEY_BITS must be 128 or 256");
  end

  localparam round_t     NR    = (KEY_BITS == 256) ? 4'd14 : 4'd10;
  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] ROUND = ST_ROUND;
  localparam logic [1:0] DONE  = ST_DONE;

  logic [1:0]          state;
  round_t              round;
  byte_t               rcon, rcon_step;
  aes_block_t          blk, sb, sr, mc, rk, rk_step, nxt_blk;
  logic [KEY_BITS-1:0] win, win_step;
  logic                accept, last_round, hold_key;

  for (genvar i = 0; i < 16; i++) begin : g_sb
    aes_sbox u_sbox (.a(blk[8*i +: 8]), .y(sb[8*i +: 8]));
  end

  always_comb begin
    sr = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[8*(4*c+r) +: 8] = sb[8*(4*((c+r)%4)+r) +: 8];
  end

  for (genvar i = 0; i < 4; i++) begin : g_mix
    aes_mixw u_mixw (.w(sr[32*i +: 32]), .y(mc[32*i +: 32]));
  end

  aes_key_expand_step #(.KEY_BITS(KEY_BITS)) u_key (
    .win      (win),
    .rcon     (rcon),
    .phase    (~round[0]),
    .next_win (win_step),
    .next_rcon(rcon_step),
    .round_key(rk_step)
  );

  // AES-256 round 1 uses the upper half of the cipher key as-is, so the window holds
  assign hold_key   = (KEY_BITS == 256) && (round == 4'd1);
  assign rk         = hold_key ? win[KEY_BITS-1 -: 128] : rk_step;
  assign last_round = (round == NR);
  assign nxt_blk    = (last_round ? sr : mc) ^ rk;

  assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = blk;
  assign bus.busy      = (state == ROUND) || (state == DONE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      round <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            state <= ROUND;
            round <= 4'd1;
          end else if (state == DONE && bus.out_ready) begin
            state <= IDLE;
          end
        end
        ROUND: begin
          if (last_round) begin
            state <= DONE;
            round <= '0;
          end else begin
            round <= round + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      blk  <= bus.in_data ^ bus.in_key[127:0];
      win  <= bus.in_key;
      rcon <= RCON_START;
    end else if (state == ROUND) begin
      blk <= nxt_blk;
      if (!hold_key) begin
        win  <= win_step;
        rcon <= rcon_step;
      end
    end
  end
endmodule

// File: tb/tb_aes_enc_core.sv
// tb/tb_aes_enc_core.sv - self-checking bench for aes_enc_core (AES-128 and AES-256 instances)
module tb_aes_enc_core;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic         iv   [2];
  logic [127:0] id   [2];
  logic [255:0] ik   [2];
  logic         ordy [2];
  logic         rdy  [2];
  logic         ov   [2];
  logic         bsy  [2];
  logic [127:0] od   [2];

  aes_enc_core_if #(.KEY_BITS(128)) if0 ();
  aes_enc_core_if #(.KEY_BITS(256)) if1 ();

  aes_enc_core #(.KEY_BITS(128)) u_dut0 (.clk(clk), .resetn(resetn), .bus(if0));
  aes_enc_core #(.KEY_BITS(256)) u_dut1 (.clk(clk), .resetn(resetn), .bus(if1));

  assign if0.in_valid  = iv[0];
  assign if0.in_data   = id[0];
  assign if0.in_key    = ik[0][127:0];
  assign if0.out_ready = ordy[0];
  assign rdy[0] = if0.in_ready;
  assign ov[0]  = if0.out_valid;
  assign bsy[0] = if0.busy;
  assign od[0]  = if0.out_data;

  assign if1.in_valid  = iv[1];
  assign if1.in_data   = id[1];
  assign if1.in_key    = ik[1];
  assign if1.out_ready = ordy[1];
  assign rdy[1] = if1.in_ready;
  assign ov[1]  = if1.out_valid;
  assign bsy[1] = if1.busy;
  assign od[1]  = if1.out_data;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference AES straight from the textbook description: full key expansion, then rounds on a byte array
  logic [7:0] sbt [256];

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, c, v;
    c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gm(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      for (int i = 0; i < 8; i++)
        v[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbt[a] = v;
    end
  endtask

  function automatic logic [127:0] aes_model(input logic [255:0] key, input int nk, input logic [127:0] pt);
    logic [7:0]   w [60][4];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   tmp [4];
    logic [7:0]   rc, x;
    logic [127:0] res;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++)
      for (int j = 0; j < 4; j++) w[i][j] = key[8*(4*i+j) +: 8];
    for (int i = nk; i < 4*(nr+1); i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[i-1][j];
      if (i % nk == 0) begin
        x = tmp[0];
        tmp[0] = sbt[tmp[1]] ^ rc;
        tmp[1] = sbt[tmp[2]];
        tmp[2] = sbt[tmp[3]];
        tmp[3] = sbt[x];
        rc = gm(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        for (int j = 0; j < 4; j++) tmp[j] = sbt[tmp[j]];
      end
      for (int j = 0; j < 4; j++) w[i][j] = w[i-nk][j] ^ tmp[j];
    end
    for (int k = 0; k < 16; k++) s[k] = pt[8*k +: 8] ^ w[k/4][k%4];
    for (int r = 1; r <= nr; r++) begin
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) t[4*c+q] = sbt[s[4*((c+q)%4)+q]];
      for (int c = 0; c < 4; c++) begin
        if (r < nr) begin
          s[4*c]   = gm(t[4*c], 8'h02) ^ gm(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gm(t[4*c+1], 8'h02) ^ gm(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm(t[4*c+2], 8'h02) ^ gm(t[4*c+3], 8'h03);
          s[4*c+3] = gm(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gm(t[4*c+3], 8'h02);
        end else begin
          for (int q = 0; q < 4; q++) s[4*c+q] = t[4*c+q];
        end
      end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ w[4*r + k/4][k%4];
    end
    for (int k = 0; k < 16; k++) res[8*k +: 8] = s[k];
    return res;
  endfunction

  // per-cycle compare against the model: at most one block in flight per instance
  int           cyc = 0;
  logic         pend [2] = '{1'b0, 1'b0};
  logic [127:0] expd [2];
  int           acc  [2];
  logic         m_ev, m_er;
  int           m_nr;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (!resetn) begin
        pend[u] = 1'b0;
      end else begin
        m_nr = (u == 0) ? 10 : 14;
        m_ev = pend[u] && (cyc - acc[u] >= m_nr + 1);
        m_er = !pend[u] || (m_ev && ordy[u]);
        chk($sformatf("u%0d out_valid", u), 256'(ov[u]), 256'(m_ev));
        chk($sformatf("u%0d busy", u), 256'(bsy[u]), 256'(pend[u]));
        chk($sformatf("u%0d in_ready", u), 256'(rdy[u]), 256'(m_er));
        if (m_ev) chk($sformatf("u%0d out_data", u), 256'(od[u]), 256'(expd[u]));
        if (m_ev && ordy[u]) pend[u] = 1'b0;
        if (iv[u] && m_er) begin
          pend[u] = 1'b1;
          expd[u] = aes_model(ik[u], (u == 0) ? 4 : 8, id[u]);
          acc[u]  = cyc;
        end
      end
    end
  end

  logic hs [2];
  logic sov [2];

  task automatic cyc_step();
    #2;
    for (int u = 0; u < 2; u++) begin
      hs[u]  = iv[u] && rdy[u] && resetn;
      sov[u] = ov[u];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int u, input logic [255:0] key, input logic [127:0] pt);
    int n;
    iv[u] = 1'b1; id[u] = pt; ik[u] = key;
    n = 0;
    do begin
      cyc_step();
      n++;
    end while (!hs[u] && n < 100);
    chk($sformatf("u%0d accept", u), 256'(hs[u]), 256'(1'b1));
    iv[u] = 1'b0;
  endtask

  task automatic wait_valid(input int u, output int n);
    n = 0;
    while (!ov[u] && n < 100) begin
      cyc_step();
      n++;
    end
    chk($sformatf("u%0d out_valid arrives", u), 256'(ov[u]), 256'(1'b1));
  endtask

  localparam logic [255:0] K128 = 256'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [255:0] K256 = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] PT   = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] CT128 = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
  localparam logic [127:0] CT256 = 128'h8960494b9049fceabf456751cab7a28e;
  localparam logic [127:0] CT0   = 128'h2e2b34ca59fa4c883b2c8aefd44be966;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [127:0] held, rp;
    logic [255:0] rk;
    resetn = 1'b0;
    for (int u = 0; u < 2; u++) begin
      iv[u] = 1'b0; ordy[u] = 1'b1; id[u] = '0; ik[u] = '0;
    end
    build_sbox();
    chk("sbox[00]", 256'(sbt[0]), 256'(8'h63));
    chk("sbox[53]", 256'(sbt[8'h53]), 256'(8'hed));
    chk("model aes128", 256'(aes_model(K128, 4, PT)), 256'(CT128));
    chk("model aes256", 256'(aes_model(K256, 8, PT)), 256'(CT256));
    chk("model aes128 zero", 256'(aes_model(256'h0, 4, 128'h0)), 256'(CT0));

    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d reset in_ready", u), 256'(rdy[u]), 256'(1'b1));
      chk($sformatf("u%0d reset out_valid", u), 256'(ov[u]), 256'(1'b0));
      chk($sformatf("u%0d reset busy", u), 256'(bsy[u]), 256'(1'b0));
    end

    // single blocks
    send(0, K128, PT);
    wait_valid(0, n);
    chk("aes128 latency", 256'(n + 1), 256'(11));
    chk("aes128 data", 256'(od[0]), 256'(CT128));
    cyc_step();
    send(1, K256, PT);
    wait_valid(1, n);
    chk("aes256 latency", 256'(n + 1), 256'(15));
    chk("aes256 data", 256'(od[1]), 256'(CT256));
    cyc_step();

    // backpressure
    ordy[0] = 1'b0;
    rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    rp = {$urandom, $urandom, $urandom, $urandom};
    send(0, rk, rp);
    wait_valid(0, n);
    held = aes_model(rk, 4, rp);
    for (int i = 0; i < 20; i++) begin
      chk("bp out_data", 256'(od[0]), 256'(held));
      chk("bp in_ready", 256'(rdy[0]), 256'(1'b0));
      chk("bp busy", 256'(bsy[0]), 256'(1'b1));
      cyc_step();
    end
    ordy[0] = 1'b1;
    cyc_step();
    chk("bp release out_valid", 256'(ov[0]), 256'(1'b0));
    chk("bp release in_ready", 256'(rdy[0]), 256'(1'b1));
    chk("bp release busy", 256'(bsy[0]), 256'(1'b0));

    // back-to-back with in_valid held high
    send(0, K128, PT);
    iv[0] = 1'b1; id[0] = 128'h0; ik[0] = 256'h0;
    n = 0;
    do begin
      cyc_step();
      n++;
    end while (!hs[0] && n < 100);
    chk("b2b second accept", 256'(hs[0]), 256'(1'b1));
    chk("b2b accept on output handshake", 256'(sov[0]), 256'(1'b1));
    iv[0] = 1'b0;
    wait_valid(0, n);
    chk("b2b spacing", 256'(n + 1), 256'(11));
    chk("b2b data", 256'(od[0]), 256'(CT0));
    cyc_step();

    // ignore in_valid while a block is in flight
    ordy[1] = 1'b0;
    send(1, K256, PT);
    for (int i = 0; i < 12; i++) begin
      iv[1] = 1'($urandom);
      id[1] = {$urandom, $urandom, $urandom, $urandom};
      ik[1] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      cyc_step();
      chk("busy no accept", 256'(hs[1]), 256'(1'b0));
    end
    iv[1] = 1'b0;
    ordy[1] = 1'b1;
    wait_valid(1, n);
    chk("busy result", 256'(od[1]), 256'(CT256));
    cyc_step();

    // reset in the middle of round 5
    send(0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    repeat (4) cyc_step();
    resetn = 1'b0;
    cyc_step();
    chk("mid reset in_ready", 256'(rdy[0]), 256'(1'b1));
    chk("mid reset out_valid", 256'(ov[0]), 256'(1'b0));
    resetn = 1'b1;
    send(0, K128, PT);
    wait_valid(0, n);
    chk("post reset data", 256'(od[0]), 256'(CT128));
    cyc_step();

    // random traffic with random backpressure on both instances
    for (int k = 0; k < 1500; k++) begin
      for (int u = 0; u < 2; u++) begin
        ordy[u] = ($urandom_range(0, 3) != 0);
        if (!iv[u]) begin
          id[u] = {$urandom, $urandom, $urandom, $urandom};
          ik[u] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
          iv[u] = ($urandom_range(0, 2) == 0);
        end
      end
      cyc_step();
      for (int u = 0; u < 2; u++) if (hs[u]) iv[u] = 1'b0;
    end
    for (int u = 0; u < 2; u++) begin
      iv[u] = 1'b0; ordy[u] = 1'b1;
    end
    repeat (20) cyc_step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
